// File: rtl/sub_add_pkg.sv
// Shared types and constants for the sequential slice adder/subtractor.
package sub_add_pkg;

   // Controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Default datapath geometry
   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_SLICE = 4;

   // Operation encoding of op_sub
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE-bit carry-look-ahead adder slice; holds no state.
module cla_slice #(
   parameter int unsigned SLICE = 4
) (
   input  logic [SLICE-1:0] i_a,
   input  logic [SLICE-1:0] i_b,
   input  logic             i_cin,
   output logic [SLICE-1:0] o_sum,
   output logic             o_cout
);

   logic [SLICE-1:0] w_g;
   logic [SLICE-1:0] w_p;
   logic [SLICE:0]   w_c;
   logic             w_acc;
   logic             w_term;

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   // Each carry is the flat sum of products of generate/propagate terms and cin
   always_comb begin
      w_c    = '0;
      w_acc  = 1'b0;
      w_term = 1'b0;
      w_c[0] = i_cin;
      for (int unsigned i = 0; i < SLICE; i++) begin
         w_acc = i_cin;
         for (int unsigned k = 0; k <= i; k++) begin
            w_acc = w_acc & w_p[k];
         end
         for (int unsigned j = 0; j <= i; j++) begin
            w_term = w_g[j];
            for (int unsigned k = j + 1; k <= i; k++) begin
               w_term = w_term & w_p[k];
            end
            w_acc = w_acc | w_term;
         end
         w_c[i+1] = w_acc;
      end
   end

   assign o_sum  = w_p ^ w_c[SLICE-1:0];
   assign o_cout = w_c[SLICE];

endmodule

// File: rtl/sub_add_seq_ctrl.sv
// Multi-cycle add/subtract: iterates one CLA slice over the operand,
// least significant slice first, with valid/ready handshakes on both sides.
import sub_add_pkg::*;

module sub_add_seq_ctrl #(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned SLICE = DEF_SLICE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;
   logic             r_carry;
   logic             r_a_sign;
   logic             r_b_sign;
   logic [CW-1:0]    r_cnt;
   logic             r_out_valid;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;

   logic [SLICE-1:0] w_sum;
   logic             w_slice_cout;
   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH-1:0] w_res_next;
   logic             w_accept;
   logic             w_last;

   cla_slice #(.SLICE(SLICE)) u_slice (
      .i_a    (r_a[SLICE-1:0]),
      .i_b    (r_b[SLICE-1:0]),
      .i_cin  (r_carry),
      .o_sum  (w_sum),
      .o_cout (w_slice_cout)
   );

   assign w_b_eff    = (op_sub == OP_SUB) ? ~b : b;
   assign w_res_next = {w_sum, r_result[WIDTH-1:SLICE]};
   assign w_last     = (r_cnt == CW'(NSLICE - 1));
   assign in_ready   = !rst && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
   assign w_accept   = in_valid && in_ready;

   // Sequencer FSM: operand/result shifting, carry chaining, flags and handshakes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_result    <= '0;
         r_carry     <= 1'b0;
         r_a_sign    <= 1'b0;
         r_b_sign    <= 1'b0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_zero      <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               r_a      <= r_a >> SLICE;
               r_b      <= r_b >> SLICE;
               r_carry  <= w_slice_cout;
               r_result <= w_res_next;
               r_cnt    <= r_cnt + 1'b1;
               if (w_last) begin
                  r_cout      <= w_slice_cout;
                  r_ovf       <= (r_a_sign == r_b_sign) && (w_res_next[WIDTH-1] != r_a_sign);
                  r_zero      <= (w_res_next == '0);
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
         // Accept is shared by IDLE and DONE; placed last so a same-edge
         // accept in DONE overrides the return to IDLE (no bubble).
         if (w_accept) begin
            r_a      <= a;
            r_b      <= w_b_eff;
            r_carry  <= op_sub;
            r_a_sign <= a[WIDTH-1];
            r_b_sign <= w_b_eff[WIDTH-1];
            r_cnt    <= '0;
            r_state  <= RUN;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign zero      = r_zero;

endmodule

// File: tb/tb_sub_add_seq_ctrl.sv
// Scoreboard bench for sub_add_seq_ctrl: the driver pushes hand-computed
// expectations, an independent monitor pops and compares on each handshake.
module tb_sub_add_seq_ctrl;

   localparam int NSL = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        op_sub = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        cout;
   logic        ovf;
   logic        zero;

   typedef struct {
      logic [31:0] res;
      logic        co;
      logic        ov;
      logic        z;
      int          acc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic seen   = 1'b0;

   sub_add_seq_ctrl #(.WIDTH(32), .SLICE(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_sub    (op_sub),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Drive one request at a negedge; waits (bounded) for acceptance and
   // optionally pushes the expected response. Returns at the next negedge.
   task automatic send(input logic sub, input logic [31:0] va, input logic [31:0] vb,
                       input logic push, input logic [31:0] er, input logic eco,
                       input logic eov, input logic ez, output int waited);
      exp_t e;
      int n;
      in_valid = 1'b1;
      op_sub   = sub;
      a        = va;
      b        = vb;
      n = 0;
      #1;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      waited = n;
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1");
      end else if (push) begin
         e.res = er; e.co = eco; e.ov = eov; e.z = ez; e.acc = cyc + 1;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      op_sub = $urandom_range(0, 1);
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
         q.delete();
      end
   endtask

   // Monitor: latency on first presentation, fields on handshake
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            seen = 1'b0;
         end else if (out_valid) begin
            if (q.size() == 0) begin
               if (!seen) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_valid: got out_valid=1 with result %h expected none", result);
                  seen = 1'b1;
               end
            end else begin
               e = q[0];
               if (!seen) begin
                  chk("latency", 32'(cyc - e.acc), 32'(NSL));
                  seen = 1'b1;
               end
               if (out_ready) begin
                  chk("result", result, e.res);
                  chk("cout", 32'(cout), 32'(e.co));
                  chk("ovf", 32'(ovf), 32'(e.ov));
                  chk("zero", 32'(zero), 32'(e.z));
                  void'(q.pop_front());
                  seen = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      int w;
      logic [31:0] held;
      int n;
      // Reset state
      #2;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready), 32'd1);

      // Directed arithmetic vectors
      send(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, w); drain();
      send(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, w); drain();
      send(1'b1, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, w); drain();
      send(1'b1, 32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, w); drain();
      send(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, w); drain();

      // Backpressure in DONE, then same-edge accept of the next op
      out_ready = 1'b0;
      send(1'b0, 32'h0000_000A, 32'h0000_0014, 1'b1, 32'h0000_001E, 1'b0, 1'b0, 1'b0, w);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("bp_valid", 32'(out_valid), 32'd1);
      held = result;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         chk("bp_hold_result", result, 32'h0000_001E);
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      chk("bp_stable", result, held);
      out_ready = 1'b1;
      send(1'b0, 32'h0000_0003, 32'h0000_0004, 1'b1, 32'h0000_0007, 1'b0, 1'b0, 1'b0, w);
      chk("b2b_no_wait", 32'(w), 32'd0);
      drain();

      // Reset in the middle of RUN discards the op
      send(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, '0, 1'b0, 1'b0, 1'b0, w);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_result", result, 32'd0);
      chk("mid_rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_idle", 32'(in_ready), 32'd1);
      repeat (12) @(negedge clk);
      send(1'b0, 32'h0000_0001, 32'h0000_0001, 1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b0, w);
      drain();
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sub_add_seq_ctrl.md
Name: sub_add_seq_ctrl

Overview:
- Multi-cycle sequencer that performs WIDTH-bit add/subtract by iterating one SLICE-bit carry-look-ahead adder slice, least significant nibble first.
- Owns operand and result shift registers, the inter-slice carry register, and the valid/ready handshakes on both sides.
- Sits between the ALU op-decode stage and the result writeback, as a low-area alternative to a full-width CLA.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle (width of the CLA slice).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- op_sub  in  1  0 = A+B, 1 = A-B; sampled on accept.
- a  in  WIDTH  operand A; sampled on accept.
- b  in  WIDTH  operand B; sampled on accept.
- out_valid  out  1  result fields are valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  sum or difference.
- cout  out  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  result == 0.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=0 during reset, out_valid=0, result=0, cout=0, ovf=0, zero=0, carry register=0.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0, slice counter 0..NSLICE-1, where NSLICE=WIDTH/SLICE.
  - DONE: out_valid=1.
- Accept: in_valid&&in_ready at edge T.
  - Latch A, B_eff = op_sub ? ~b : b, carry = op_sub.
  - Latch sign bits a[WIDTH-1] and B_eff[WIDTH-1].
  - Counter=0, go to RUN.
- RUN, each cycle: the slice adds the low SLICE bits of the A and B_eff registers plus the carry register.
  - The sum nibble shifts into result from the top.
  - A and B_eff shift right by SLICE.
  - The carry register takes the slice carry out.
  - Counter increments.
- On the edge where counter==NSLICE-1 completes:
  - cout = final slice carry.
  - ovf = (a_sign==beff_sign) && (result[WIDTH-1]!=a_sign).
  - zero = (result==0).
  - Go to DONE.
- Latency: out_valid rises after edge T+NSLICE (8 cycles after accept at defaults).
- DONE:
  - All outputs are held stable while out_ready=0.
  - Handshake out_valid&&out_ready at an edge: go to IDLE.
  - in_ready=out_ready in DONE. If in_valid is also high, the new op is accepted on the same edge and the state goes directly to RUN (back-to-back, no bubble).
- in_valid while in RUN is ignored; the requester must hold it until in_ready.
- op_sub, a and b changing after accept have no effect on the current operation.
- rst asserted mid-RUN or in DONE: partial/held result is discarded, all outputs return to reset values, the op is lost, and no out_valid is produced for it.
- Arithmetic: modulo 2^WIDTH; no saturation; flags are computed only at completion.

Decomposition:
- Shared package sub_add_pkg:
  - state enum {IDLE, RUN, DONE};
  - constants for the default WIDTH/SLICE;
  - the op encoding (OP_ADD=0, OP_SUB=1).
- One sub-module, cla_slice, instantiated once: combinational SLICE-bit carry-look-ahead adder.
  - Per-bit generate/propagate, look-ahead carries from cin.
  - Outputs sum[SLICE-1:0] and cout.
- The controller holds all registers; the slice has no state.

Test Plan:
- Add 0x7FFFFFFF + 0x00000001, out_ready=1 -> out_valid exactly 8 cycles after accept; result=0x80000000, ovf=1, cout=0, zero=0.
- Add 0xFFFFFFFF + 0x00000001 -> result=0x00000000, cout=1, zero=1, ovf=0 (carry crosses all 8 slices).
- Sub 0x00000000 - 0x00000001 -> result=0xFFFFFFFF, cout=0 (borrow), ovf=0, zero=0. Sub 5 - 5 -> result=0, cout=1, zero=1.
- Sub 0x80000000 - 0x00000001 -> result=0x7FFFFFFF, ovf=1, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result/flags stable, in_ready=0. Then out_ready=1 with in_valid=1 (3+4) -> same-edge accept, next out_valid 8 cycles later with result=7; no idle bubble.
- Assert rst at slice 3 of 0x12345678+0x11111111 -> all outputs 0 immediately, IDLE after release, no out_valid. A fresh 1+1 then yields result=2.
